// File: rtl/framebuf_pkg.sv
// rtl/framebuf_pkg.sv - shared FSM type, default geometry and word-offset helper for framebuf scan-out
package framebuf_pkg;

  localparam int FB_ADDR_W     = 13;
  localparam int FB_DATA_W     = 16;
  localparam int FB_BANK_WORDS = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SHIFT,
    ST_LATCH
  } fb_state_e;

  function automatic int unsigned fb_word_offset(input int unsigned row,
                                                 input int unsigned col,
                                                 input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/led_shifter.sv
// rtl/led_shifter.sv - parallel-load MSB-first shifter with divided SCLK and load/done handshake
module led_shifter #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              done_o,
  output logic              sdi_o,
  output logic              sclk_o
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sreg_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DIV_W-1:0]  div_q;
  logic              sclk_q;
  logic              active_q;
  logic              phase_end;

  assign phase_end = active_q && (div_q == DIV_LAST);
  // done marks the final high-phase cycle so the caller can move on without a dead cycle
  assign done_o    = phase_end && sclk_q && (bit_q == '0);
  assign sdi_o     = sreg_q[DATA_W-1];
  assign sclk_o    = sclk_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q   <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      sclk_q   <= 1'b0;
      active_q <= 1'b0;
    end else if (load_i) begin
      sreg_q   <= load_data_i;
      bit_q    <= BIT_LAST;
      div_q    <= '0;
      sclk_q   <= 1'b0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (phase_end) begin
        div_q  <= '0;
        sclk_q <= ~sclk_q;
        if (sclk_q) begin
          // data advances on the falling edge, giving a full low phase of setup
          sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
          if (bit_q == '0) begin
            active_q <= 1'b0;
          end else begin
            bit_q <= bit_q - 1'b1;
          end
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/framebuf_scanout.sv
// rtl/framebuf_scanout.sv - scans one FrameBuf bank row by row into the LED driver shift chain
module framebuf_scanout
  import framebuf_pkg::*;
#(
  parameter int ADDR_W  = FB_ADDR_W,
  parameter int DATA_W  = FB_DATA_W,
  parameter int COLS    = 32,
  parameter int ROWS    = 128,
  parameter int RD_LAT  = 1,
  parameter int CLK_DIV = 2,
  parameter int LATCH_W = 2
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic                     frame_start,
  input  logic                     bank_sel,
  output logic [ADDR_W-1:0]        mem_address,
  output logic                     mem_chipselect,
  output logic                     mem_clken,
  output logic                     mem_write,
  output logic [DATA_W/8-1:0]      mem_byteenable,
  input  logic [DATA_W-1:0]        mem_readdata,
  output logic                     led_sdi,
  output logic                     led_sclk,
  output logic                     led_latch,
  output logic [$clog2(ROWS)-1:0]  led_row,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     underrun
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int LAT_W = (LATCH_W > 1) ? $clog2(LATCH_W) : 1;
  localparam int unsigned BANK_WORDS = 2 ** (ADDR_W - 1);

  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(LATCH_W - 1);
  localparam logic             WAIT_LAST = 1'(RD_LAT - 1);

  if (ROWS * COLS > BANK_WORDS) begin : g_bad_geometry
    $error("framebuf_scanout: ROWS*COLS does not fit in one bank");
  end
  if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_rd_lat
    $error("framebuf_scanout: RD_LAT must be 1 or 2");
  end
  if (CLK_DIV < 1 || LATCH_W < 1) begin : g_bad_timing
    $error("framebuf_scanout: CLK_DIV and LATCH_W must be at least 1");
  end
  if (ADDR_W == FB_ADDR_W && BANK_WORDS != FB_BANK_WORDS) begin : g_bad_bank
    $error("framebuf_scanout: bank size disagrees with FrameBuf default");
  end

  function automatic logic [ADDR_W-1:0] word_addr(input logic             bank,
                                                  input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    int unsigned base;
    base = bank ? BANK_WORDS : 32'd0;
    return ADDR_W'(base + fb_word_offset(32'(row), 32'(col), COLS));
  endfunction

  fb_state_e          state_q;
  logic               bank_q;
  logic [ROW_W-1:0]   row_q;
  logic [COL_W-1:0]   col_q;
  logic               wait_q;
  logic [LAT_W-1:0]   lat_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               cs_q;
  logic               busy_q;
  logic               done_q;
  logic               underrun_q;
  logic               latch_q;
  logic [ROW_W-1:0]   led_row_q;

  logic [ROW_W-1:0]   row_d;
  logic [COL_W-1:0]   col_d;
  logic               shift_load;
  logic               shift_done;

  assign row_d      = row_q + 1'b1;
  assign col_d      = col_q + 1'b1;
  assign shift_load = (state_q == ST_WAIT) && (wait_q == WAIT_LAST);

  led_shifter #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk_i       (clk_clk),
    .rst_ni      (reset_reset_n),
    .load_i      (shift_load),
    .load_data_i (mem_readdata),
    .done_o      (shift_done),
    .sdi_o       (led_sdi),
    .sclk_o      (led_sclk)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= ST_IDLE;
      bank_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      wait_q     <= 1'b0;
      lat_q      <= '0;
      addr_q     <= '0;
      cs_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      latch_q    <= 1'b0;
      led_row_q  <= '0;
    end else begin
      cs_q       <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= frame_start && (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            bank_q  <= bank_sel;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= word_addr(bank_sel, '0, '0);
            cs_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          wait_q  <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_q <= ST_SHIFT;
          end else begin
            wait_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (shift_done) begin
            if (col_q != COL_LAST) begin
              col_q   <= col_d;
              addr_q  <= word_addr(bank_q, row_q, col_d);
              cs_q    <= 1'b1;
              state_q <= ST_FETCH;
            end else begin
              lat_q     <= '0;
              latch_q   <= 1'b1;
              led_row_q <= row_q;
              state_q   <= ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          if (lat_q == LAT_LAST) begin
            latch_q <= 1'b0;
            if (row_q != ROW_LAST) begin
              row_q   <= row_d;
              col_q   <= '0;
              addr_q  <= word_addr(bank_q, row_d, '0);
              cs_q    <= 1'b1;
              state_q <= ST_FETCH;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign mem_clken      = cs_q;
  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;
  assign led_latch      = latch_q;
  assign led_row        = led_row_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_framebuf_scanout.sv
// tb/tb_framebuf_scanout.sv - scoreboard bench for framebuf_scanout (two parameter sets)
`timescale 1ns/1ps
module tb_framebuf_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected event, value %0h", name, act);
  endtask

  logic [15:0] ram [0:8191];
  logic [15:0] words [8] = '{16'hA5F0, 16'h0001, 16'h8000, 16'hFFFF,
                             16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

  // DUT A: COLS=2 ROWS=2 RD_LAT=1 CLK_DIV=1
  logic        rst_a = 1'b0, fs_a = 1'b0, bs_a = 1'b0;
  logic [12:0] addr_a;
  logic        cs_a, ce_a, we_a, sdi_a, sclk_a, latch_a, busy_a, done_a, ur_a;
  logic [1:0]  be_a;
  logic [15:0] rd_a;
  logic [0:0]  row_a;

  framebuf_scanout #(.ADDR_W(13), .DATA_W(16), .COLS(2), .ROWS(2),
                     .RD_LAT(1), .CLK_DIV(1), .LATCH_W(2)) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_a), .frame_start(fs_a), .bank_sel(bs_a),
    .mem_address(addr_a), .mem_chipselect(cs_a), .mem_clken(ce_a), .mem_write(we_a),
    .mem_byteenable(be_a), .mem_readdata(rd_a), .led_sdi(sdi_a), .led_sclk(sclk_a),
    .led_latch(latch_a), .led_row(row_a), .busy(busy_a), .frame_done(done_a),
    .underrun(ur_a));

  always @(posedge clk) if (cs_a && ce_a) rd_a <= ram[addr_a];

  // DUT B: RD_LAT=2 CLK_DIV=3
  logic        rst_b = 1'b0, fs_b = 1'b0, bs_b = 1'b0;
  logic [12:0] addr_b;
  logic        cs_b, ce_b, we_b, sdi_b, sclk_b, latch_b, busy_b, done_b, ur_b;
  logic [1:0]  be_b;
  logic [15:0] rd_b, p0_b;
  logic [0:0]  row_b;

  framebuf_scanout #(.ADDR_W(13), .DATA_W(16), .COLS(2), .ROWS(2),
                     .RD_LAT(2), .CLK_DIV(3), .LATCH_W(2)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_b), .frame_start(fs_b), .bank_sel(bs_b),
    .mem_address(addr_b), .mem_chipselect(cs_b), .mem_clken(ce_b), .mem_write(we_b),
    .mem_byteenable(be_b), .mem_readdata(rd_b), .led_sdi(sdi_b), .led_sclk(sclk_b),
    .led_latch(latch_b), .led_row(row_b), .busy(busy_b), .frame_done(done_b),
    .underrun(ur_b));

  always @(posedge clk) begin
    if (cs_b && ce_b) p0_b <= ram[addr_b];
    rd_b <= p0_b;
  end

  // scoreboard queues
  int q_addr_a[$], q_row_a[$], q_done_a[$], q_ur_a[$];
  bit q_bit_a[$];
  int q_addr_b[$], q_done_b[$];
  bit q_bit_b[$];
  int done_seen_a = 0, done_seen_b = 0;

  task automatic expect_frame_a(input logic b, input int n);
    for (int w = 0; w < 4; w++) begin
      q_addr_a.push_back((b ? 4096 : 0) + w);
      for (int k = 15; k >= 0; k--) q_bit_a.push_back(words[(b ? 4 : 0) + w][k]);
    end
    q_row_a.push_back(0);
    q_row_a.push_back(1);
    q_done_a.push_back(n + 1 + 2 * (2 * 34) + 2 * 2);
  endtask

  task automatic expect_frame_b(input int n);
    for (int w = 0; w < 4; w++) begin
      q_addr_b.push_back(w);
      for (int k = 15; k >= 0; k--) q_bit_b.push_back(words[w][k]);
    end
    q_done_b.push_back(n + 1 + 4 * (1 + 2 + 96) + 2 * 2);
  endtask

  task automatic start_a(input logic b, output int n);
    @(posedge clk); #1;
    fs_a = 1'b1; bs_a = b; n = cyc;
    @(posedge clk); #1;
    fs_a = 1'b0;
  endtask

  task automatic wait_done_a(input int target, input int budget);
    for (int i = 0; i < budget && done_seen_a < target; i++) @(posedge clk);
    if (done_seen_a < target) flag("timeout_frame_done_a", done_seen_a);
    #1;
  endtask

  // monitor A
  logic prev_sclk_a = 1'b0, prev_latch_a = 1'b0;
  int   lat_run_a = 0;
  always @(negedge clk) begin
    if (cs_a) begin
      if (q_addr_a.size() == 0) flag("addr_a", addr_a);
      else check("addr_a", addr_a, q_addr_a.pop_front());
      check("clken_a", ce_a, 1);
    end
    if (sclk_a && !prev_sclk_a) begin
      if (q_bit_a.size() == 0) flag("sdi_a", sdi_a);
      else check("sdi_a", sdi_a, q_bit_a.pop_front());
    end
    if (latch_a && !prev_latch_a) begin
      if (q_row_a.size() == 0) flag("led_row_a", row_a);
      else check("led_row_a", row_a, q_row_a.pop_front());
    end
    if (!latch_a && prev_latch_a) check("latch_width_a", lat_run_a, 2);
    lat_run_a = latch_a ? lat_run_a + 1 : 0;
    if (done_a) begin
      done_seen_a++;
      if (q_done_a.size() == 0) flag("frame_done_a", cyc);
      else check("frame_done_cycle_a", cyc, q_done_a.pop_front());
    end
    if (ur_a) begin
      if (q_ur_a.size() == 0) flag("underrun_a", cyc);
      else check("underrun_cycle_a", cyc, q_ur_a.pop_front());
    end
    prev_sclk_a  = sclk_a;
    prev_latch_a = latch_a;
  end

  // monitor B: data, phase lengths and SDI setup/hold around SCLK
  logic prev_sclk_b = 1'b0, prev_sdi_b = 1'b0;
  int   hi_run_b = 0, lo_run_b = 0, stab_b = 0, bidx_b = 0;
  always @(negedge clk) begin
    if (cs_b) begin
      if (q_addr_b.size() == 0) flag("addr_b", addr_b);
      else check("addr_b", addr_b, q_addr_b.pop_front());
    end
    stab_b = (sdi_b == prev_sdi_b) ? stab_b + 1 : 0;
    if (sclk_b && !prev_sclk_b) begin
      if (q_bit_b.size() == 0) flag("sdi_b", sdi_b);
      else check("sdi_b", sdi_b, q_bit_b.pop_front());
      check("sdi_setup_b", (stab_b >= 3), 1);
      if (bidx_b != 0) check("sclk_low_phase_b", lo_run_b, 3);
      bidx_b = (bidx_b + 1) % 16;
    end
    if (!sclk_b && prev_sclk_b) check("sclk_high_phase_b", hi_run_b, 3);
    if (sclk_b) check("sdi_hold_b", sdi_b, prev_sdi_b);
    if (sclk_b) hi_run_b = prev_sclk_b ? hi_run_b + 1 : 1;
    else        lo_run_b = prev_sclk_b ? 1 : lo_run_b + 1;
    if (done_b) begin
      done_seen_b++;
      if (q_done_b.size() == 0) flag("frame_done_b", cyc);
      else check("frame_done_cycle_b", cyc, q_done_b.pop_front());
    end
    if (ur_b) flag("underrun_b", cyc);
    prev_sclk_b = sclk_b;
    prev_sdi_b  = sdi_b;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int d;
    for (int i = 0; i < 8192; i++) ram[i] = 16'h0;
    for (int i = 0; i < 4; i++) begin
      ram[i]        = words[i];
      ram[4096 + i] = words[4 + i];
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_a", {addr_a, cs_a, ce_a, we_a, sdi_a, sclk_a, latch_a,
                              row_a, busy_a, done_a, ur_a}, 0);
    check("reset_byteenable_a", be_a, 32'h3);
    check("reset_outputs_b", {addr_b, cs_b, ce_b, we_b, sdi_b, sclk_b, latch_b,
                              row_b, busy_b, done_b, ur_b}, 0);
    check("reset_byteenable_b", be_b, 32'h3);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);

    // bank 0 frame
    start_a(1'b0, n);
    expect_frame_a(1'b0, n);
    @(negedge clk);
    check("busy_after_start_a", busy_a, 1);
    wait_done_a(1, 400);

    // bank 1 frame with bank_sel toggling mid-frame
    start_a(1'b1, n);
    expect_frame_a(1'b1, n);
    repeat (30) @(posedge clk);
    #1 bs_a = 1'b0;
    repeat (40) @(posedge clk);
    #1 bs_a = 1'b1;
    repeat (20) @(posedge clk);
    #1 bs_a = 1'b0;
    wait_done_a(2, 400);

    // frame_start during SHIFT of the first word
    start_a(1'b0, n);
    expect_frame_a(1'b0, n);
    repeat (18) @(posedge clk);
    #1;
    fs_a = 1'b1;
    q_ur_a.push_back(cyc + 1);
    @(posedge clk); #1;
    fs_a = 1'b0;
    wait_done_a(3, 400);

    // frame_start coincident with frame_done
    start_a(1'b0, n);
    expect_frame_a(1'b0, n);
    d = n + 141;
    while (cyc < d) begin
      @(posedge clk); #1;
    end
    fs_a = 1'b1;
    bs_a = 1'b0;
    expect_frame_a(1'b0, d);
    @(negedge clk);
    check("coincident_busy_low", busy_a, 0);
    check("coincident_frame_done", done_a, 1);
    @(posedge clk); #1;
    fs_a = 1'b0;
    @(negedge clk);
    check("coincident_busy_high", busy_a, 1);
    check("coincident_fetch", cs_a, 1);
    wait_done_a(5, 400);

    // asynchronous reset during SHIFT of the last word
    start_a(1'b1, n);
    expect_frame_a(1'b1, n);
    repeat (110) @(posedge clk);
    #3;
    check("busy_before_reset_a", busy_a, 1);
    rst_a = 1'b0;
    #1;
    check("async_reset_outputs_a", {addr_a, cs_a, ce_a, we_a, sdi_a, sclk_a, latch_a,
                                    row_a, busy_a, done_a, ur_a}, 0);
    check("async_reset_byteenable_a", be_a, 32'h3);
    q_addr_a.delete();
    q_bit_a.delete();
    q_row_a.delete();
    q_done_a.delete();
    q_ur_a.delete();
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("idle_after_reset_busy", busy_a, 0);
    check("no_done_after_reset", done_seen_a, 5);

    start_a(1'b0, n);
    expect_frame_a(1'b0, n);
    wait_done_a(6, 400);

    // DUT B: slower read latency and divided SCLK
    @(posedge clk); #1;
    fs_b = 1'b1;
    bs_b = 1'b0;
    n = cyc;
    @(posedge clk); #1;
    fs_b = 1'b0;
    expect_frame_b(n);
    for (int i = 0; i < 1000 && done_seen_b < 1; i++) @(posedge clk);
    if (done_seen_b < 1) flag("timeout_frame_done_b", done_seen_b);
    repeat (5) @(posedge clk);
    #1;

    check("leftover_addr_a", q_addr_a.size(), 0);
    check("leftover_bits_a", q_bit_a.size(), 0);
    check("leftover_rows_a", q_row_a.size(), 0);
    check("leftover_done_a", q_done_a.size(), 0);
    check("leftover_underrun_a", q_ur_a.size(), 0);
    check("leftover_addr_b", q_addr_b.size(), 0);
    check("leftover_bits_b", q_bit_b.size(), 0);
    check("leftover_done_b", q_done_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
